// File: rtl/l1_sram_pkg.sv
// l1_sram_pkg
// Shared constants and types for the L1 cache line SRAM controller:
//   DATA_WIDTH / ADDR_WIDTH / NUM_WMASKS  - line geometry of the SRAM macro
//   NUM_LINES                             - number of lines swept during init
//   rid_e                                 - read requester id (IF / LS)
//   state_e                               - controller FSM state
//   rid_other()                           - the requester that is not the argument

package l1_sram_pkg;

  localparam int unsigned DATA_WIDTH = 1024;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;
  localparam int unsigned NUM_LINES  = 1 << ADDR_WIDTH;

  // Encoding matters: the value is what rd_rsp_id reports.
  typedef enum logic {
    RID_IF = 1'b0,
    RID_LS = 1'b1
  } rid_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic rid_e rid_other(input rid_e r);
    return (r == RID_IF) ? RID_LS : RID_IF;
  endfunction

endpackage

// File: rtl/l1_rd_rr_arb.sv
// l1_rd_rr_arb
// Two-input round-robin arbiter for the SRAM read port.
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - arbitration enable; no grant is issued while low
//   req[1:0]    - requests, bit index = rid_e (0 = IF, 1 = LS)
//   blk[1:0]    - per-input block mask (same-line write collision)
//   gnt[1:0]    - one-hot-or-zero grant, combinational in the request cycle
// The preferred requester (rr_ptr) is tried first; if it is idle or blocked
// the other one may take the slot. After any grant the pointer moves to the
// requester that was not granted.

module l1_rd_rr_arb
  import l1_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] blk,
  output logic [1:0] gnt
);

  rid_e       rr_ptr_q;
  rid_e       rr_ptr_d;
  logic [1:0] elig;
  logic       pref;
  logic       alt;

  assign pref = rr_ptr_q;
  assign alt  = rid_other(rr_ptr_q);

  always_comb begin
    elig = req & ~blk & {2{en}};
    gnt  = 2'b00;
    if (elig[pref]) begin
      gnt[pref] = 1'b1;
    end else if (elig[alt]) begin
      gnt[alt] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt[RID_IF]) begin
      rr_ptr_d = RID_LS;
    end else if (gnt[RID_LS]) begin
      rr_ptr_d = RID_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= RID_IF;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/l1_sram_ctrl.sv
// l1_sram_ctrl
// Sequencer and port sharer for the L1 cache line SRAM (1 masked write port,
// 1 read port, both clocked by clk).
//   clk, rst_n                       - clock, synchronous active-low reset
//   init_done                        - high once every line has been zeroed
//   if_rd_* / ls_rd_*                - instruction-fetch / load-store reads
//   rd_rsp_valid/_id/_data           - read response, one cycle after grant
//   rf_wr_*                          - full-line refill write
//   st_wr_*                          - byte-masked store write
//   sram_csb0/addr0/wmask0/din0      - SRAM write port (active-low select)
//   sram_csb1/addr1, sram_dout1      - SRAM read port
// After reset the FSM spends 256 cycles in ST_INIT writing zeros to every
// line, then serves requests in ST_RUN. Grants are combinational in the
// request cycle; a read to the line being written that cycle is held off.

module l1_sram_ctrl
  import l1_sram_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,

  input  logic                  if_rd_req,
  input  logic [ADDR_WIDTH-1:0] if_rd_addr,
  output logic                  if_rd_gnt,
  input  logic                  ls_rd_req,
  input  logic [ADDR_WIDTH-1:0] ls_rd_addr,
  output logic                  ls_rd_gnt,

  output logic                  rd_rsp_valid,
  output logic                  rd_rsp_id,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,

  input  logic                  rf_wr_req,
  input  logic [ADDR_WIDTH-1:0] rf_wr_addr,
  input  logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_gnt,
  input  logic                  st_wr_req,
  input  logic [ADDR_WIDTH-1:0] st_wr_addr,
  input  logic [NUM_WMASKS-1:0] st_wr_wmask,
  input  logic [DATA_WIDTH-1:0] st_wr_data,
  output logic                  st_wr_gnt,

  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  // ---------------------------------------------------------------------------
  // Sequencer FSM: zeroing sweep, then normal service
  // ---------------------------------------------------------------------------
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;
  logic                  run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign init_done = init_done_q;

  // Reset is folded in so no grant or SRAM select escapes while rst_n is low.
  assign run = rst_n && (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Write arbitration: RF first, unless ST has been refused STARVE_LIMIT times
  // ---------------------------------------------------------------------------
  logic [StarveW-1:0]    starve_q;
  logic [StarveW-1:0]    starve_d;
  logic                  starved;
  logic                  st_win;
  logic                  rf_win;
  logic                  wr_act;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign starved = (starve_q == StarveW'(STARVE_LIMIT));
  assign st_win  = run && st_wr_req && (!rf_wr_req || starved);
  assign rf_win  = run && rf_wr_req && !st_win;
  assign wr_act  = st_win || rf_win;
  assign wr_addr = st_win ? st_wr_addr : rf_wr_addr;

  assign rf_wr_gnt = rf_win;
  assign st_wr_gnt = st_win;

  always_comb begin
    starve_d = '0;
    if (run && st_wr_req && !st_win) begin
      starve_d = starved ? starve_q : starve_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read arbitration with same-line write blocking
  // ---------------------------------------------------------------------------
  logic [1:0] rd_req;
  logic [1:0] rd_blk;
  logic [1:0] rd_gnt;

  assign rd_req[RID_IF] = if_rd_req;
  assign rd_req[RID_LS] = ls_rd_req;
  assign rd_blk[RID_IF] = wr_act && (if_rd_addr == wr_addr);
  assign rd_blk[RID_LS] = wr_act && (ls_rd_addr == wr_addr);

  l1_rd_rr_arb u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .req   (rd_req),
    .blk   (rd_blk),
    .gnt   (rd_gnt)
  );

  assign if_rd_gnt = rd_gnt[RID_IF];
  assign ls_rd_gnt = rd_gnt[RID_LS];

  // ---------------------------------------------------------------------------
  // SRAM port drive
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_csb0   = 1'b1;
    sram_addr0  = rf_wr_addr;
    sram_wmask0 = '1;
    sram_din0   = rf_wr_data;
    if (!rst_n) begin
      sram_csb0 = 1'b1;
    end else if (state_q == ST_INIT) begin
      sram_csb0   = 1'b0;
      sram_addr0  = init_cnt_q;
      sram_wmask0 = '1;
      sram_din0   = '0;
    end else if (st_win) begin
      sram_csb0   = 1'b0;
      sram_addr0  = st_wr_addr;
      sram_wmask0 = st_wr_wmask;
      sram_din0   = st_wr_data;
    end else if (rf_win) begin
      sram_csb0   = 1'b0;
      sram_addr0  = rf_wr_addr;
      sram_wmask0 = '1;
      sram_din0   = rf_wr_data;
    end
  end

  assign sram_csb1  = ~|rd_gnt;
  assign sram_addr1 = rd_gnt[RID_LS] ? ls_rd_addr : if_rd_addr;

  // ---------------------------------------------------------------------------
  // Read response tracking and starvation counter
  // ---------------------------------------------------------------------------
  logic rsp_valid_q;
  rid_e rsp_id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= RID_IF;
    end else begin
      starve_q    <= starve_d;
      rsp_valid_q <= |rd_gnt;
      if (|rd_gnt) begin
        rsp_id_q <= rd_gnt[RID_LS] ? RID_LS : RID_IF;
      end
    end
  end

  // A response in flight when reset arrives is suppressed immediately.
  assign rd_rsp_valid = rsp_valid_q && rst_n;
  assign rd_rsp_id    = rsp_id_q;
  assign rd_rsp_data  = sram_dout1;

endmodule

// File: tb/tb_l1_sram_ctrl.sv
module tb_l1_sram_ctrl;
  import l1_sram_pkg::*;

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int NW  = NUM_WMASKS;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          init_done;
  logic          if_rd_req, ls_rd_req, if_rd_gnt, ls_rd_gnt;
  logic [AW-1:0] if_rd_addr, ls_rd_addr;
  logic          rd_rsp_valid, rd_rsp_id;
  logic [DW-1:0] rd_rsp_data;
  logic          rf_wr_req, rf_wr_gnt, st_wr_req, st_wr_gnt;
  logic [AW-1:0] rf_wr_addr, st_wr_addr;
  logic [DW-1:0] rf_wr_data, st_wr_data;
  logic [NW-1:0] st_wr_wmask;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [NW-1:0] sram_wmask0;
  logic [DW-1:0] sram_din0, sram_dout1;

  l1_sram_ctrl #(.STARVE_LIMIT(LIM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_done    (init_done),
    .if_rd_req    (if_rd_req),
    .if_rd_addr   (if_rd_addr),
    .if_rd_gnt    (if_rd_gnt),
    .ls_rd_req    (ls_rd_req),
    .ls_rd_addr   (ls_rd_addr),
    .ls_rd_gnt    (ls_rd_gnt),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_id    (rd_rsp_id),
    .rd_rsp_data  (rd_rsp_data),
    .rf_wr_req    (rf_wr_req),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .rf_wr_gnt    (rf_wr_gnt),
    .st_wr_req    (st_wr_req),
    .st_wr_addr   (st_wr_addr),
    .st_wr_wmask  (st_wr_wmask),
    .st_wr_data   (st_wr_data),
    .st_wr_gnt    (st_wr_gnt),
    .sram_csb0    (sram_csb0),
    .sram_addr0   (sram_addr0),
    .sram_wmask0  (sram_wmask0),
    .sram_din0    (sram_din0),
    .sram_csb1    (sram_csb1),
    .sram_addr1   (sram_addr1),
    .sram_dout1   (sram_dout1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got low64 %h expected low64 %h (t=%0t)", nm, act[63:0], exp[63:0],
               $time);
    end
  endtask

  function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] old,
                                               input logic [DW-1:0] dat,
                                               input logic [NW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NW; b++) if (m[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NW-1:0] rand_mask();
    logic [NW-1:0] v;
    for (int i = 0; i < NW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // SRAM macro: synchronous write with byte mask, synchronous read.
  logic [DW-1:0] sram_arr [NUM_LINES];
  always @(posedge clk) begin
    if (!sram_csb1) sram_dout1 <= sram_arr[sram_addr1];
    if (!sram_csb0) sram_arr[sram_addr0] <= apply_mask(sram_arr[sram_addr0], sram_din0,
                                                       sram_wmask0);
  end

  // ---------------------------------------------------------------------------
  // Reference model: architectural state of the controller plus the expected
  // memory contents. Evaluated at the falling edge (inputs are stable from
  // just after the rising edge) and then advanced for the next rising edge.
  // ---------------------------------------------------------------------------
  bit            m_valid = 0;
  bit            m_init;
  int            m_cnt, m_starve, m_rr, m_id;
  bit            m_pend;
  logic [DW-1:0] m_line;
  logic [DW-1:0] m_mem [NUM_LINES];
  bit            e_if_g, e_ls_g, e_rf_g, e_st_g;

  always @(negedge clk) begin : ref_model
    bit            if_ok, ls_ok, wr;
    bit            e_csb0, e_csb1;
    logic [AW-1:0] e_a0, e_a1;
    logic [NW-1:0] e_m0;
    logic [DW-1:0] e_d0;

    e_if_g = 0; e_ls_g = 0; e_rf_g = 0; e_st_g = 0;
    e_csb0 = 1; e_csb1 = 1; e_a0 = '0; e_a1 = '0; e_m0 = '1; e_d0 = '0;
    if (rst_n && m_valid && m_init) begin
      e_csb0 = 0; e_a0 = AW'(m_cnt); e_m0 = '1; e_d0 = '0;
    end else if (rst_n && m_valid) begin
      e_st_g = st_wr_req && (!rf_wr_req || m_starve == LIM);
      e_rf_g = rf_wr_req && !e_st_g;
      wr = e_st_g || e_rf_g;
      if (e_st_g) begin
        e_csb0 = 0; e_a0 = st_wr_addr; e_m0 = st_wr_wmask; e_d0 = st_wr_data;
      end else if (e_rf_g) begin
        e_csb0 = 0; e_a0 = rf_wr_addr; e_m0 = '1; e_d0 = rf_wr_data;
      end
      if_ok = if_rd_req && !(wr && if_rd_addr == e_a0);
      ls_ok = ls_rd_req && !(wr && ls_rd_addr == e_a0);
      if (m_rr == 0) begin
        if (if_ok) e_if_g = 1; else if (ls_ok) e_ls_g = 1;
      end else begin
        if (ls_ok) e_ls_g = 1; else if (if_ok) e_if_g = 1;
      end
      if (e_if_g) begin e_csb1 = 0; e_a1 = if_rd_addr; end
      if (e_ls_g) begin e_csb1 = 0; e_a1 = ls_rd_addr; end
    end

    if (m_valid) begin
      chk("init_done", 64'(init_done), 64'(!m_init));
      chk("if_rd_gnt", 64'(if_rd_gnt), 64'(e_if_g));
      chk("ls_rd_gnt", 64'(ls_rd_gnt), 64'(e_ls_g));
      chk("rf_wr_gnt", 64'(rf_wr_gnt), 64'(e_rf_g));
      chk("st_wr_gnt", 64'(st_wr_gnt), 64'(e_st_g));
      chk("sram_csb0", 64'(sram_csb0), 64'(e_csb0));
      chk("sram_csb1", 64'(sram_csb1), 64'(e_csb1));
      if (!e_csb0) begin
        chk("sram_addr0", 64'(sram_addr0), 64'(e_a0));
        chk("sram_wmask0_lo", sram_wmask0[63:0], e_m0[63:0]);
        chk("sram_wmask0_hi", sram_wmask0[127:64], e_m0[127:64]);
        chk_w("sram_din0", sram_din0, e_d0);
      end
      if (!e_csb1) chk("sram_addr1", 64'(sram_addr1), 64'(e_a1));
      chk("rd_rsp_valid", 64'(rd_rsp_valid), 64'(rst_n && m_pend));
      if (rst_n && m_pend) begin
        chk("rd_rsp_id", 64'(rd_rsp_id), 64'(m_id));
        chk_w("rd_rsp_data", rd_rsp_data, m_line);
      end
    end

    // Advance model state across the coming rising edge.
    if (!rst_n) begin
      m_valid = 1; m_init = 1; m_cnt = 0; m_starve = 0; m_rr = 0; m_pend = 0; m_id = 0;
    end else if (m_valid && m_init) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NUM_LINES) begin m_init = 0; m_cnt = 0; end
      m_pend = 0;
    end else if (m_valid) begin
      m_pend = e_if_g || e_ls_g;
      if (m_pend) begin
        m_line = m_mem[e_a1];
        m_id   = e_ls_g ? 1 : 0;
      end
      if (!e_csb0) m_mem[e_a0] = apply_mask(m_mem[e_a0], e_d0, e_m0);
      if (st_wr_req && !e_st_g) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else m_starve = 0;
      if (e_if_g) m_rr = 1; else if (e_ls_g) m_rr = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc_next();
    @(posedge clk);
    #1;
  endtask

  // Starts just after rst_n rises; ends at the falling edge of cycle 257.
  task automatic init_sweep(input string tag);
    for (int n = 1; n <= 257; n++) begin
      @(negedge clk);
      if (n <= 256) begin
        chk({tag, "_init_csb0"}, 64'(sram_csb0), 64'(0));
        chk({tag, "_init_addr0"}, 64'(sram_addr0), 64'(n - 1));
        chk({tag, "_init_done_low"}, 64'(init_done), 64'(0));
        chk({tag, "_init_no_if_gnt"}, 64'(if_rd_gnt), 64'(0));
      end else begin
        chk({tag, "_init_done_257"}, 64'(init_done), 64'(1));
      end
      if (n < 257) cyc_next();
    end
  endtask

  logic [DW-1:0] exp_line;

  initial begin
    rst_n = 0;
    if_rd_req = 1; if_rd_addr = 8'h05; ls_rd_req = 0; ls_rd_addr = '0;
    rf_wr_req = 1; rf_wr_addr = 8'h09; rf_wr_data = '1;
    st_wr_req = 0; st_wr_addr = '0; st_wr_wmask = '0; st_wr_data = '0;
    repeat (3) cyc_next();

    // Reset state, with requests present but gated.
    @(negedge clk);
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_rsp_valid", 64'(rd_rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rd_rsp_id), 64'(0));
    chk("rst_if_gnt", 64'(if_rd_gnt), 64'(0));
    chk("rst_rf_gnt", 64'(rf_wr_gnt), 64'(0));
    chk("rst_csb0", 64'(sram_csb0), 64'(1));
    chk("rst_csb1", 64'(sram_csb1), 64'(1));

    // Release; IF and LS wait through the whole sweep on different lines.
    cyc_next();
    rst_n = 1; rf_wr_req = 0;
    if_rd_req = 1; if_rd_addr = 8'h20; ls_rd_req = 1; ls_rd_addr = 8'h21;
    init_sweep("boot");
    chk("rr_c257_if", 64'(if_rd_gnt), 64'(1));
    chk("rr_c257_ls", 64'(ls_rd_gnt), 64'(0));
    cyc_next();
    @(negedge clk);
    chk("rr_c258_ls", 64'(ls_rd_gnt), 64'(1));
    chk("rr_c258_if", 64'(if_rd_gnt), 64'(0));
    chk("rr_c258_rsp_id", 64'(rd_rsp_id), 64'(0));
    chk_w("rr_c258_data", rd_rsp_data, '0);
    cyc_next();
    @(negedge clk);
    chk("rr_c259_if", 64'(if_rd_gnt), 64'(1));
    chk("rr_c259_rsp_id", 64'(rd_rsp_id), 64'(1));
    cyc_next();

    // Same-line collision: RF writes 0x12 while LS reads it.
    if_rd_req = 0; ls_rd_req = 1; ls_rd_addr = 8'h12;
    rf_wr_req = 1; rf_wr_addr = 8'h12;
    for (int b = 0; b < NW; b++) rf_wr_data[b*8 +: 8] = 8'hA5;
    @(negedge clk);
    chk("coll_rf_gnt", 64'(rf_wr_gnt), 64'(1));
    chk("coll_ls_blocked", 64'(ls_rd_gnt), 64'(0));
    cyc_next();
    rf_wr_req = 0;
    @(negedge clk);
    chk("coll_ls_gnt", 64'(ls_rd_gnt), 64'(1));
    cyc_next();
    ls_rd_req = 0;
    @(negedge clk);
    chk("coll_rsp_valid", 64'(rd_rsp_valid), 64'(1));
    chk("coll_rsp_id", 64'(rd_rsp_id), 64'(1));
    chk_w("coll_rsp_data", rd_rsp_data, rf_wr_data);
    cyc_next();

    // Store starvation: RF held on 0x40, ST on 0x03 byte 0 only.
    rf_wr_req = 1; rf_wr_addr = 8'h40; rf_wr_data = rand_line();
    st_wr_req = 1; st_wr_addr = 8'h03; st_wr_wmask = '0; st_wr_wmask[0] = 1'b1;
    st_wr_data = '1; st_wr_data[7:0] = 8'h3C;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("starve_st_gnt_c%0d", k), 64'(st_wr_gnt), 64'(k == 5));
      chk($sformatf("starve_rf_gnt_c%0d", k), 64'(rf_wr_gnt), 64'(k != 5));
      cyc_next();
    end
    rf_wr_req = 0; st_wr_req = 0;
    if_rd_req = 1; if_rd_addr = 8'h03;
    @(negedge clk);
    chk("starve_rd_gnt", 64'(if_rd_gnt), 64'(1));
    cyc_next();
    if_rd_req = 0;
    exp_line = '0;
    exp_line[7:0] = 8'h3C;
    @(negedge clk);
    chk_w("starve_line3", rd_rsp_data, exp_line);
    cyc_next();

    // Store with an empty mask is granted but changes nothing.
    st_wr_req = 1; st_wr_addr = 8'h03; st_wr_wmask = '0; st_wr_data = '1;
    @(negedge clk);
    chk("nomask_st_gnt", 64'(st_wr_gnt), 64'(1));
    cyc_next();
    st_wr_req = 0; ls_rd_req = 1; ls_rd_addr = 8'h03;
    @(negedge clk);
    chk("nomask_rd_gnt", 64'(ls_rd_gnt), 64'(1));
    cyc_next();
    ls_rd_req = 0;
    @(negedge clk);
    chk_w("nomask_line3", rd_rsp_data, exp_line);
    cyc_next();

    // Reset the cycle after an IF grant: response dropped, sweep restarts.
    if_rd_req = 1; if_rd_addr = 8'h07;
    @(negedge clk);
    chk("rstmid_if_gnt", 64'(if_rd_gnt), 64'(1));
    cyc_next();
    if_rd_req = 0; rst_n = 0;
    @(negedge clk);
    chk("rstmid_no_rsp", 64'(rd_rsp_valid), 64'(0));
    chk("rstmid_csb0", 64'(sram_csb0), 64'(1));
    chk("rstmid_csb1", 64'(sram_csb1), 64'(1));
    cyc_next();
    rst_n = 1;
    init_sweep("rst");
    cyc_next();

    // Randomised traffic on a small line set to force collisions.
    for (int c = 0; c < 4000; c++) begin
      if (!if_rd_req || e_if_g) begin
        if_rd_req = ($urandom_range(0, 3) != 0); if_rd_addr = AW'($urandom_range(0, 7));
      end
      if (!ls_rd_req || e_ls_g) begin
        ls_rd_req = ($urandom_range(0, 3) != 0); ls_rd_addr = AW'($urandom_range(0, 7));
      end
      if (!rf_wr_req || e_rf_g) begin
        rf_wr_req = ($urandom_range(0, 2) != 0); rf_wr_addr = AW'($urandom_range(0, 7));
        rf_wr_data = rand_line();
      end
      if (!st_wr_req || e_st_g) begin
        st_wr_req = ($urandom_range(0, 1) != 0); st_wr_addr = AW'($urandom_range(0, 7));
        st_wr_data = rand_line();
        st_wr_wmask = ($urandom_range(0, 7) == 0) ? '0 : rand_mask();
      end
      cyc_next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l1_sram_ctrl.md
# l1_sram_ctrl

Controller that sequences and shares the L1 cache line SRAM (256 lines × 1024 bits, one byte-masked write port, one read port). It zero-initialises every line after reset. It arbitrates the read port between instruction fetch (IF) and load/store (LS), and the write port between line refill (RF) and byte-masked store (ST). It also blocks same-line read/write collisions. It sits between the fetch/LSU/miss-handler logic and the SRAM macro.

## Interface
- DATA_WIDTH, 1024: line width in bits.
- ADDR_WIDTH, 8: line index width; 256 lines.
- NUM_WMASKS, 128: byte-enable count, DATA_WIDTH/8.
- STARVE_LIMIT, 4: consecutive denied ST cycles before ST overrides RF.
- clk  in  1  single clock; the SRAM's clk0 and clk1 are both tied to it.
- rst_n  in  1  reset; synchronous, active-low.
- init_done  out  1  high once the zeroing sweep completes.
- if_rd_req / if_rd_addr / if_rd_gnt  in / in / out  1 / ADDR_WIDTH / 1  IF read request.
- ls_rd_req / ls_rd_addr / ls_rd_gnt  in / in / out  1 / ADDR_WIDTH / 1  LS read request.
- rd_rsp_valid  out  1  read data valid.
- rd_rsp_id  out  1  owner of the response; 0 = IF, 1 = LS.
- rd_rsp_data  out  DATA_WIDTH  line data.
- rf_wr_req / rf_wr_addr / rf_wr_data / rf_wr_gnt  in / in / in / out  1 / ADDR_WIDTH / DATA_WIDTH / 1  full-line refill.
- st_wr_req / st_wr_addr / st_wr_wmask / st_wr_data / st_wr_gnt  in / in / in / in / out  1 / ADDR_WIDTH / NUM_WMASKS / DATA_WIDTH / 1  masked store.
- sram_csb0 / sram_addr0 / sram_wmask0 / sram_din0  out  1 / ADDR_WIDTH / NUM_WMASKS / DATA_WIDTH  SRAM write port.
- sram_csb1 / sram_addr1  out  1 / ADDR_WIDTH  SRAM read port.
- sram_dout1  in  DATA_WIDTH  SRAM read data.

## Operation
- FSM states are INIT and RUN. Reset forces INIT with init counter = 0.
- INIT:
  - Each cycle writes zeros to line = counter, with all wmask bits set, and increments the counter.
  - After line 255 is written, the FSM moves to RUN.
  - All grants stay 0 and sram_csb1 stays 1.
- RUN, write arbitration:
  - RF has priority over ST.
  - ST wins instead when starve_cnt == STARVE_LIMIT.
  - starve_cnt increments on any cycle with st_wr_req=1 and st_wr_gnt=0. It saturates at STARVE_LIMIT and clears when ST is granted or st_wr_req=0.
  - RF drives wmask = all ones. ST drives st_wr_wmask unchanged.
- RUN, read arbitration:
  - Two-way round-robin. rr_ptr names the preferred requester; its reset value is IF.
  - A read whose address equals the granted write's address this cycle is blocked and not granted.
  - If the preferred requester is blocked or idle, the other requester is granted when it is eligible.
  - After any grant, rr_ptr points to the non-granted requester.
- Requesters hold req and addr/data stable until gnt. gnt is combinational in the request cycle. At most one read grant and one write grant per cycle.
- rd_rsp_id is the registered id of the grant. rd_rsp_data passes sram_dout1 through.
- A reset mid-operation drops any in-flight response (rd_rsp_valid = 0) and restarts INIT. A partially swept array is fully re-zeroed.

## Timing
- Reset values: init_done 0, rd_rsp_valid 0, rd_rsp_id 0, all gnt 0, rr_ptr IF, starve_cnt 0.
- While rst_n is low, sram_csb0 = sram_csb1 = 1, gated combinationally.
- Grant cycle N: the SRAM port is driven combinationally during cycle N and the macro samples at the posedge ending cycle N.
- Read latency is 1 cycle: rd_rsp_valid is high in cycle N+1 only, with data valid by the posedge ending N+1.
- A write granted in cycle N is visible to a read granted in cycle N+1 or later. A read of the same line in cycle N is blocked.
- INIT lasts exactly 256 cycles after the first posedge with rst_n = 1. init_done rises in the cycle after the last init write.
- Reads on the same line as a write that is retried every cycle stall until the write is granted. No read starvation bound is defined.

## Structure
- Package l1_sram_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH and NUM_WMASKS constants.
  - The requester-id enum (RID_IF, RID_LS).
  - The FSM state enum (ST_INIT, ST_RUN).
- One sub-module, l1_rd_rr_arb: the two-input round-robin with per-input block masks and the rr_ptr register.

## Test plan
- Reset release -> 256 writes to lines 0..255 with din = 0 and wmask = all ones. init_done = 1 in cycle 257. No grants before that cycle.
- IF and LS both requesting continuously, different lines -> grants alternate IF, LS, IF. Each rd_rsp_id matches the grant from the previous cycle.
- RF writes line 0x12 with data 0xA5 pattern while LS reads line 0x12 in the same cycle -> LS blocked. LS is granted next cycle and returns the 0xA5 line.
- RF held high, ST requesting line 0x03 with wmask = 0x1 -> ST granted on the 5th cycle (STARVE_LIMIT = 4). Only byte 0 of line 0x03 changes.
- rst_n asserted in the cycle after an IF grant -> no rd_rsp_valid. INIT restarts from line 0.
- ST write with wmask = 0 -> ST granted, SRAM line contents unchanged.
